// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl
//   Write sequencer for the 4x32 character RAM behind the VGA text renderer.
//   Received UART bytes go into a small FIFO. In IDLE one byte per cycle is
//   popped and decoded: printable bytes are written at the cursor, and
//   newline / backspace / form-feed move the cursor. A 128-cell blank sweep
//   runs after reset and on every form-feed.
//
// Ports
//   clk       system clock
//   reset     asynchronous active-low reset
//   rx_data   received byte, qualified by rx_valid
//   rx_valid  single-cycle strobe per received byte
//   ram_we    RAM write enable, one cycle per cell written
//   ram_row   RAM write row
//   ram_col   RAM write column
//   ram_data  RAM write data
//   cur_row   cursor row
//   cur_col   cursor column
//   busy      high while a clear sweep is running
//   overflow  sticky: a byte was dropped because the FIFO was full
module text_cursor_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  BLANK      = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ram_we,
  output logic [1:0] ram_row,
  output logic [4:0] ram_col,
  output logic [7:0] ram_data,
  output logic [1:0] cur_row,
  output logic [4:0] cur_col,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   fill_q, fill_d;
  logic          fifo_empty, fifo_full;
  logic          pop, push_ok, drop;
  logic [7:0]    head;

  // ----------------------------------------------------------------- FSM
  state_e     state_q, state_d;
  logic [7:0] sweep_q, sweep_d;  // bit 7 marks "all 128 cells issued"
  logic       ram_we_q, ram_we_d;
  logic [1:0] ram_row_q, ram_row_d;
  logic [4:0] ram_col_q, ram_col_d;
  logic [7:0] ram_data_q, ram_data_d;
  logic [1:0] cur_row_q, cur_row_d;
  logic [4:0] cur_col_q, cur_col_d;
  logic       busy_q, busy_d;
  logic       ovf_q, ovf_d;

  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == FULL_CNT);
  assign head       = mem_q[rd_ptr_q];

  // Pop is decided from the registered fill level, so an empty FIFO can
  // never be pushed and popped in the same cycle.
  assign pop     = (state_q == ST_IDLE) && !fifo_empty;
  assign push_ok = rx_valid && (!fifo_full || pop);
  assign drop    = rx_valid && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    ram_we_d   = 1'b0;
    ram_row_d  = ram_row_q;
    ram_col_d  = ram_col_q;
    ram_data_d = ram_data_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q | drop;

    case (state_q)
      ST_CLEAR: begin
        if (sweep_q[7]) begin
          // Closing cycle of the sweep; a drop in this same cycle still
          // leaves overflow set.
          state_d   = ST_IDLE;
          cur_row_d = '0;
          cur_col_d = '0;
          busy_d    = 1'b0;
          ovf_d     = drop;
        end else begin
          ram_we_d   = 1'b1;
          ram_row_d  = sweep_q[6:5];
          ram_col_d  = sweep_q[4:0];
          ram_data_d = BLANK;
          sweep_d    = sweep_q + 8'd1;
        end
      end

      ST_IDLE: begin
        if (pop) begin
          if (head >= 8'h20 && head <= 8'h7E) begin
            ram_we_d   = 1'b1;
            ram_row_d  = cur_row_q;
            ram_col_d  = cur_col_q;
            ram_data_d = head;
            cur_col_d  = cur_col_q + 5'd1;
            if (cur_col_q == 5'd31) cur_row_d = cur_row_q + 2'd1;
          end else if (head == 8'h0A || head == 8'h0D) begin
            cur_col_d = '0;
            cur_row_d = cur_row_q + 2'd1;
          end else if (head == 8'h08) begin
            // Blank goes to the post-retreat position.
            cur_col_d  = cur_col_q - 5'd1;
            cur_row_d  = (cur_col_q == 5'd0) ? cur_row_q - 2'd1 : cur_row_q;
            ram_we_d   = 1'b1;
            ram_row_d  = (cur_col_q == 5'd0) ? cur_row_q - 2'd1 : cur_row_q;
            ram_col_d  = cur_col_q - 5'd1;
            ram_data_d = BLANK;
          end else if (head == 8'h0C) begin
            state_d = ST_CLEAR;
            sweep_d = '0;
            busy_d  = 1'b1;
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      state_q    <= ST_CLEAR;
      sweep_q    <= '0;
      ram_we_q   <= 1'b0;
      ram_row_q  <= '0;
      ram_col_q  <= '0;
      ram_data_q <= '0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      busy_q     <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      ram_we_q   <= ram_we_d;
      ram_row_q  <= ram_row_d;
      ram_col_q  <= ram_col_d;
      ram_data_q <= ram_data_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_row  = ram_row_q;
  assign ram_col  = ram_col_q;
  assign ram_data = ram_data_q;
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: doc/text_cursor_ctrl.md
# text_cursor_ctrl

- Sequences all writes into the 4-row × 32-column character RAM that feeds the VGA text renderer.
- Accepts received UART bytes through a small FIFO and interprets control codes (newline, backspace, form-feed).
- Drives the RAM write port, tracks the cursor, and performs full-screen blank sweeps at power-up and on form-feed.
- Sits between the UART receiver (and its single-pulser) and the write port of the dual-port text RAM; the cursor outputs feed the seven-segment display.

## Interface

Parameters:
- FIFO_DEPTH, 4: byte FIFO entries; power of two, ≥2.
- BLANK, 8'h20: character written by clear sweeps and backspace.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte, valid when rx_valid=1.
- rx_valid  input  1  single-cycle pulse per received byte.
- ram_we  output  1  RAM write enable, one cycle per cell written.
- ram_row  output  2  RAM write row.
- ram_col  output  5  RAM write column.
- ram_data  output  8  RAM write data.
- cur_row  output  2  cursor row.
- cur_col  output  5  cursor column.
- busy  output  1  1 while a clear sweep is in progress.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.

## Operation

- All outputs are registered.
- Reset values: ram_we=0, ram_row=0, ram_col=0, ram_data=0, cur_row=0, cur_col=0, busy=1, overflow=0.
- On reset the FIFO is emptied and the FSM enters CLEAR with its sweep counter at 0.

FIFO:
- A push occurs when rx_valid=1.
- A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Otherwise the byte is dropped and overflow is set to 1.
- Simultaneous push and pop on an empty FIFO is not possible, because a pop requires not-empty in the prior state.

FSM states:
- CLEAR:
  - Each cycle: ram_we=1, ram_data=BLANK, address taken from a 7-bit sweep counter (row = cnt[6:5], col = cnt[4:0]), then the counter increments.
  - After cnt=127 is issued, the next cycle sets cur_row=0, cur_col=0, busy=0, clears overflow, and goes to IDLE.
  - The FIFO is not popped in CLEAR but continues accepting pushes.
- IDLE:
  - If the FIFO is not empty, pop one byte and decode it; otherwise ram_we=0.
  - One byte is processed per cycle.

Decode of a popped byte (from cursor position r,c):
- 8'h20–8'h7E (printable):
  - Write the byte at (r,c).
  - Cursor advances to c+1.
  - If c=31, the cursor moves to col 0, row r+1 mod 4.
- 8'h0A or 8'h0D (newline):
  - No write.
  - Cursor moves to col 0, row r+1 mod 4.
- 8'h08 (backspace):
  - Cursor moves to c−1.
  - If c=0, the cursor moves to col 31, row r−1 mod 4 (row 0 goes to row 3).
  - BLANK is written at the new position.
- 8'h0C (form-feed):
  - No write this cycle; busy=1, counter=0, enter CLEAR.
  - Bytes still in the FIFO are processed after the sweep completes.
- Any other byte: discarded, no write, cursor unchanged.
- The row and column never hold out-of-range values; wrap arithmetic is modulo 4 and modulo 32.

## Timing

- rx_valid at edge N, FIFO empty and state IDLE:
  - Byte is stored at N.
  - Popped and decoded in the cycle after N.
  - ram_we, address and data are visible after edge N+1.
  - cur_row and cur_col update at the same edge N+1.
- ram_row, ram_col and ram_data always carry the pre-advance cursor position for printable bytes.
- Back-to-back rx_valid is sustained at 1 byte/cycle in IDLE with no loss.
- Clear sweep timing:
  - Exactly 128 consecutive ram_we cycles.
  - busy deasserts 129 cycles after CLEAR entry.
  - The power-up sweep begins at the first clk edge after reset is released.
- Reset asserted mid-sweep or mid-stream:
  - Outputs return to their reset values immediately.
  - FIFO contents are lost.
  - The sweep restarts from cnt=0.

## Test plan

- Reset release:
  - Required: 128 writes of 8'h20 covering (0,0)…(3,31) in order.
  - Then busy=0, cursor (0,0), overflow=0.
- Send "H","I" after the sweep:
  - Required: write 8'h48 at (0,0), then 8'h49 at (0,1); cursor ends at (0,2).
- Cursor at (3,31), send "A":
  - Required: write at (3,31); cursor wraps to (0,0).
- Cursor at (1,5):
  - Send 8'h0D: cursor goes to (2,0), no ram_we.
  - Then send 8'h08: BLANK written at (1,31), cursor (1,31).
- Send 8'h0C followed by 6 bytes during the sweep:
  - Required: 4 bytes retained, overflow=1 during the sweep.
  - overflow clears when the sweep ends; the 4 retained bytes are then written in order.
- Pulse reset low at sweep cycle 60:
  - Required: ram_we=0 immediately; the sweep restarts at (0,0) after release.
